// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with start-aligned bit timer and valid/ready output
// Optional even-parity check is built when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int MCLK = 100000000,
   parameter int BAUD = 115200,
   parameter int WORD = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frameErr_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int BIT_CNT  = MCLK / BAUD - 1;
   localparam int HALF_CNT = (MCLK / BAUD) / 2 - 1;
   localparam logic [WORD-1:0] BIT_LIM  = WORD'(BIT_CNT);
   localparam logic [WORD-1:0] HALF_LIM = WORD'(HALF_CNT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state_q;
   logic [1:0]      sync_q;
   logic [WORD-1:0] timer_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic [7:0]      data_q;
   logic            valid_q;
   logic            frame_err_q;
   logic            overrun_q;
`ifdef UART_RX_PARITY_EN
   logic            par_err_q;
`endif

   logic            rxs;
   logic [WORD-1:0] limit_d;
   logic            tick_d;
   logic            bad_frame_d;

   assign rxs     = sync_q[1];
   assign limit_d = (state_q == S_START) ? HALF_LIM : BIT_LIM;
   assign tick_d  = (timer_q == limit_d);
`ifdef UART_RX_PARITY_EN
   assign bad_frame_d = !rxs || par_err_q;
`else
   assign bad_frame_d = !rxs;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         sync_q      <= 2'b11;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         sync_q      <= {sync_q[0], rx_i};
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (valid_q && ready_i)
            valid_q <= 1'b0;

         if (state_q != S_IDLE && !en_i) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
         end else begin
            if (state_q != S_IDLE)
               timer_q <= tick_d ? '0 : timer_q + 1'b1;
            case (state_q)
               S_IDLE: begin
                  if (en_i && !rxs) begin
                     state_q <= S_START;
                     timer_q <= '0;
                  end
               end
               S_START: begin
                  // A start bit that is high again at mid-bit is a glitch
                  if (tick_d) begin
                     if (!rxs) begin
                        state_q   <= S_DATA;
                        bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                        par_err_q <= 1'b0;
`endif
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
               S_DATA: begin
                  if (tick_d) begin
                     shift_q   <= {rxs, shift_q[7:1]};
                     bit_idx_q <= bit_idx_q + 1'b1;
                     if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= S_PARITY;
`else
                        state_q <= S_STOP;
`endif
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (tick_d) begin
                     par_err_q <= ^{shift_q, rxs};
                     state_q   <= S_STOP;
                  end
               end
`endif
               S_STOP: begin
                  // Leaving at mid-stop lets a back-to-back start bit be caught
                  if (tick_d) begin
                     state_q <= S_IDLE;
                     if (bad_frame_d) begin
                        frame_err_q <= 1'b1;
                     end else if (valid_q && !ready_i) begin
                        overrun_q <= 1'b1;
                     end else begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign frameErr_o = frame_err_q;
   assign overrun_o  = overrun_q;
   assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (MCLK=16, BAUD=1)
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // Stop-bit sample edge, counted from the negedge the start bit is driven
   localparam int LOAD = 11 + 16 * (NB - 1);

   logic       clk, rst_i, en_i, rx_i, ready_i;
   logic [7:0] data_o;
   logic       valid_o, frameErr_o, overrun_o, busy_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fe_cnt = 0, ov_cnt = 0, vr_cnt = 0;
   int fe_at = 0, ov_at = 0, vr_at = 0, last_t0 = 0;
   logic fe_busy = 1'b1;
   logic valid_prev = 1'b0;
   logic [7:0] rs_data;
   logic rs_valid, rs_busy, rs_fe, rs_ov;

   uart_rx #(.MCLK(16), .BAUD(1), .WORD(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .rx_i(rx_i),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .frameErr_o(frameErr_o), .overrun_o(overrun_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frameErr_o) begin fe_cnt++; fe_at = cyc; fe_busy = busy_o; end
      if (overrun_o) begin ov_cnt++; ov_at = cyc; end
      if (valid_o && !valid_prev) begin vr_cnt++; vr_at = cyc; end
      valid_prev = valid_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                       input logic ready_pulse, input int rst_idx);
      logic [10:0] bits;
      bits = 11'h7FF;
      bits[0] = 1'b0;
      bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
      bits[9] = (^b) ^ par_flip;
      bits[10] = stop_bit;
`else
      bits[9] = stop_bit ^ (par_flip & 1'b0);
`endif
      last_t0 = cyc;
      for (int i = 0; i < NB * 16; i++) begin
         rx_i = bits[i / 16];
         if (ready_pulse) ready_i = (i == LOAD - 1);
         if (rst_idx >= 0) begin
            if (i == rst_idx) rst_i = 1'b1;
            if (i == rst_idx + 1) begin
               rs_data = data_o; rs_valid = valid_o; rs_busy = busy_o;
               rs_fe = frameErr_o; rs_ov = overrun_o;
            end
            if (i == rst_idx + 5) rst_i = 1'b0;
         end
         @(negedge clk);
      end
      rx_i = 1'b1;
      ready_i = 1'b0;
   endtask

   task automatic accept();
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
   endtask

   initial begin
      int vr_before;
      rst_i = 1'b1; en_i = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_data", data_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_frameErr", frameErr_o, 0);
      check("rst_overrun", overrun_o, 0);
      check("rst_busy", busy_o, 0);
      rst_i = 1'b0;
      repeat (3) @(negedge clk);

      send(8'hA5, 1'b1, 1'b0, 1'b0, -1);
      check("a5_data", data_o, 8'hA5);
      check("a5_valid", valid_o, 1);
      check("a5_load_time", vr_at, last_t0 + LOAD);
      check("a5_no_ferr", fe_cnt, 0);
      repeat (5) @(negedge clk);
      check("a5_valid_held", valid_o, 1);
      accept();
      check("a5_accepted", valid_o, 0);

      send(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      check("3c_ferr_cnt", fe_cnt, 1);
      check("3c_ferr_time", fe_at, last_t0 + LOAD);
      check("3c_idle_on_ferr", fe_busy, 0);
      check("3c_valid", valid_o, 0);
      repeat (24) @(negedge clk);
      check("3c_busy_settled", busy_o, 0);
      check("3c_ferr_once", fe_cnt, 1);

      rx_i = 1'b0;
      repeat (4) @(negedge clk);
      rx_i = 1'b1;
      @(negedge clk);
      check("glitch_busy_n5", busy_o, 1);
      repeat (5) @(negedge clk);
      check("glitch_busy_n10", busy_o, 1);
      @(negedge clk);
      check("glitch_busy_n11", busy_o, 0);
      repeat (10) @(negedge clk);
      check("glitch_no_ferr", fe_cnt, 1);
      check("glitch_no_ovr", ov_cnt, 0);
      check("glitch_valid", valid_o, 0);

      send(8'h11, 1'b1, 1'b0, 1'b0, -1);
      check("11_data", data_o, 8'h11);
      check("11_valid", valid_o, 1);
      send(8'h22, 1'b1, 1'b0, 1'b0, -1);
      check("ovr_cnt", ov_cnt, 1);
      check("ovr_time", ov_at, last_t0 + LOAD);
      check("ovr_data_kept", data_o, 8'h11);
      check("ovr_valid", valid_o, 1);
      send(8'h22, 1'b1, 1'b0, 1'b1, -1);
      check("same_edge_data", data_o, 8'h22);
      check("same_edge_valid", valid_o, 1);
      check("same_edge_no_ovr", ov_cnt, 1);
      accept();
      check("22_accepted", valid_o, 0);

      send(8'hFF, 1'b1, 1'b0, 1'b0, 86);
      check("inrst_data", rs_data, 0);
      check("inrst_valid", rs_valid, 0);
      check("inrst_busy", rs_busy, 0);
      check("inrst_ferr", rs_fe, 0);
      check("inrst_ovr", rs_ov, 0);
      repeat (4) @(negedge clk);
      check("post_rst_valid", valid_o, 0);
      check("post_rst_data", data_o, 0);
      vr_before = vr_cnt;
      send(8'h5A, 1'b1, 1'b0, 1'b0, -1);
      check("5a_data", data_o, 8'h5A);
      check("5a_valid", valid_o, 1);
      check("5a_single_load", vr_cnt, vr_before + 1);
      check("5a_no_ferr", fe_cnt, 1);
      check("5a_no_ovr", ov_cnt, 1);
      accept();

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b0, 1'b0, -1);
      check("par_ok_data", data_o, 8'h07);
      check("par_ok_valid", valid_o, 1);
      accept();
      send(8'h07, 1'b1, 1'b1, 1'b0, -1);
      check("par_bad_ferr", fe_cnt, 2);
      check("par_bad_ferr_time", fe_at, last_t0 + LOAD);
      check("par_bad_valid", valid_o, 0);
`endif

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART: it recovers 8-bit frames (start bit, 8 data bits LSB-first, optional parity, 1 stop bit) from the asynchronous `rx_i` line. It runs directly from the system clock with its own start-bit-aligned bit timer, so sampling lands mid-bit regardless of the free-running baud clock used by the transmit side. Received bytes are presented on a valid/ready handshake to the host-side logic, with frame-error and overrun flags.

## Interface

- `MCLK`, default 100000000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate in bits/s.
- `WORD`, default 16: bit-timer counter width; must hold `MCLK/BAUD - 1`.
- `clk_i` input, 1 bit: system clock; all logic is on its rising edge.
- `rst_i` input, 1 bit: asynchronous, active-high reset.
- `en_i` input, 1 bit: receiver enable.
- `rx_i` input, 1 bit: serial line, asynchronous to `clk_i`, idle high.
- `data_o` output, 8 bits: last received byte.
- `valid_o` output, 1 bit: `data_o` holds an unconsumed byte.
- `ready_i` input, 1 bit: consumer accepts `data_o` when `valid_o && ready_i`.
- `frameErr_o` output, 1 bit: one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
- `overrun_o` output, 1 bit: one-cycle pulse when a good frame completes while `valid_o` is still high.
- `busy_o` output, 1 bit: high in every state except IDLE.

## Operation

- `rx_i` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `rxs`.
- Constants:
  - `BIT_CNT = MCLK/BAUD - 1`
  - `HALF_CNT = (MCLK/BAUD)/2 - 1`
  - Integer division in both.
- The bit timer counts 0..limit. When it reaches the limit it clears to 0 and the current state acts.
- IDLE:
  - `en_i && rxs==0`: go to START, clear the timer.
- START:
  - At `HALF_CNT`, `rxs==0`: go to DATA, clear the timer and the bit index.
  - At `HALF_CNT`, `rxs==1`: treat as a glitch; return to IDLE with no flags.
- DATA:
  - At each `BIT_CNT`, shift `rxs` into the shift register, LSB first.
  - After the 8th bit, go to STOP (or PARITY).
- STOP, at `BIT_CNT`:
  - `rxs==1` and `valid_o==0`: load `data_o` from the shift register, set `valid_o`.
  - `rxs==1` and `valid_o==1`: pulse `overrun_o`. The new byte is dropped; `data_o`/`valid_o` are unchanged.
  - `rxs==0`: pulse `frameErr_o`, drop the byte.
  - In all three cases, return to IDLE on the same edge.
- Handshake:
  - `valid_o` clears on the edge where `valid_o && ready_i`.
  - If a load and an accept happen on the same edge, the accept is processed first. The new byte loads, `valid_o` stays 1, and there is no overrun.
- `en_i` low in any non-IDLE state: return to IDLE on the next edge and clear the timer and bit index. `valid_o`/`data_o` are untouched.
- Reset mid-frame: the frame is abandoned. The block then waits for a fresh falling edge.

## Timing

- Reset values:
  - `data_o = 0`, `valid_o = 0`, `frameErr_o = 0`, `overrun_o = 0`, `busy_o = 0`.
  - State IDLE, synchronizer flops 1.
- Input latency: a falling edge on `rx_i` is seen in IDLE 2 cycles later (synchronizer).
- Sample points: data bit k is sampled `(HALF_CNT+1) + (k+1)*(BIT_CNT+1)` cycles after START entry.
- Output latency: `valid_o`, `frameErr_o` and `overrun_o` are registered and assert on the edge that samples the stop bit.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE is re-entered half a bit before the stop bit ends.
- Flag width: `frameErr_o` and `overrun_o` are exactly one cycle wide.

## Configuration

- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP. It samples one bit at `BIT_CNT`.
  - Even parity is checked over the 8 data bits plus the parity bit.
  - On mismatch, the frame still runs through STOP. There, `frameErr_o` pulses and the byte is dropped, even if the stop bit is good.
- Not defined:
  - No PARITY state; the frame is 10 bits.
  - Parity logic is absent.

## Test plan

All scenarios use `MCLK=16`, `BAUD=1` (`BIT_CNT=15`, `HALF_CNT=7`).

- Send 0xA5 with a good stop bit, `ready_i=0` -> `data_o=0xA5`, `valid_o=1` held. Raising `ready_i` for one cycle clears `valid_o`.
- Send 0x3C with the stop bit driven 0 -> one-cycle `frameErr_o`, `valid_o` stays 0, state back to IDLE.
- Pulse `rx_i` low for 4 cycles -> START is entered, then IDLE at the half-bit check. No flags; `busy_o` drops.
- Send 0x11, leave it unaccepted, then send 0x22 -> `overrun_o` pulses at the second stop sample and `data_o` remains 0x11. Repeat with `ready_i=1` on the load edge -> `data_o=0x22`, no overrun.
- Assert `rst_i` during data bit 4 of 0xFF, release, then send 0x5A -> all outputs are 0 during reset and the only delivered byte is 0x5A.
- With `UART_RX_PARITY_EN`: send 0x07 with parity 1 -> valid. Send 0x07 with parity 0 -> `frameErr_o`, no `valid_o`.
